ram_fill_fsm: RTL

RAM_FILL_FSM -- requirements
Module: ram_fill_fsm

---
 rtl/ram_fill_pkg.sv | 19 +
 rtl/counter_en.sv | 39 +++
 rtl/ram_fill_fsm.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ram_fill_pkg.sv
// Shared types for the RAM fill engine.
//   fill_state_e : controller states (idle, filling, one-cycle finish).
//   fill_mode_e  : data pattern selector as presented on the mode input.
package ram_fill_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StFin  = 2'd2
    } fill_state_e;

    typedef enum logic [1:0] {
        ModeIdent = 2'd0,
        ModeConst = 2'd1,
        ModeXor   = 2'd2,
        ModeRsvd  = 2'd3
    } fill_mode_e;

endpackage

// File: rtl/counter_en.sv
// Free-running up counter with synchronous clear and count enable.
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset, clears the count
//   clr   : synchronous clear to zero (has priority over en)
//   en    : increment by one, wrapping modulo 2**WIDTH
//   count : current count value
module counter_en #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ram_fill_fsm.sv
// RAM fill engine: on a start pulse, writes one word per cycle to every address
// from first_addr up to last_addr inclusive (wrapping at the top of the RAM),
// with data chosen by mode: address (IDENT/RSVD), constant (CONST) or
// address XOR mask (XOR). An abort during the fill stops further writes.
//   clk, rst       : clock and asynchronous active-low reset
//   start          : begin a fill (honoured in idle only)
//   mode           : fill pattern, latched on start
//   first_addr     : first address written, latched on start
//   last_addr      : last address written (inclusive), latched on start
//   fill_val       : constant or XOR mask, latched on start
//   abort          : stop an in-progress fill
//   mem_addr/data  : registered RAM write address and data
//   mem_wren       : registered RAM write enable
//   busy           : high while filling
//   fin_strobe     : one-cycle pulse after a fill completes normally
//   abort_strobe   : one-cycle pulse after a fill is aborted
module ram_fill_fsm
    import ram_fill_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic [DATA_W-1:0] fill_val,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              busy,
    output logic              fin_strobe,
    output logic              abort_strobe
);

    fill_state_e       state_q, state_d;
    fill_mode_e        mode_q, mode_d;
    logic [ADDR_W-1:0] first_q, first_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_wren_q, mem_wren_d;
    logic              fin_q, fin_d;
    logic              abort_q, abort_d;

    // Offset of the write currently presented on the memory outputs.
    logic [ADDR_W-1:0] offset;
    logic              cnt_clr;
    logic              cnt_en;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] next_addr;

    counter_en #(
        .WIDTH (ADDR_W)
    ) u_addr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (offset)
    );

    function automatic logic [DATA_W-1:0] fill_data(
        input fill_mode_e        m,
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] v
    );
        logic [DATA_W-1:0] a_ext;
        a_ext = DATA_W'(a);
        case (m)
            ModeConst: return v;
            ModeXor:   return a_ext ^ v;
            default:   return a_ext;
        endcase
    endfunction

    // Modular difference: span == L-1, so a full-depth fill (first == last+1)
    // naturally runs the offset through every value.
    assign span      = last_q - first_q;
    assign next_addr = first_q + offset + 1'b1;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        first_d    = first_q;
        last_d     = last_q;
        val_d      = val_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_wren_d = 1'b0;
        fin_d      = 1'b0;
        abort_d    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StFill;
                    mode_d     = fill_mode_e'(mode);
                    first_d    = first_addr;
                    last_d     = last_addr;
                    val_d      = fill_val;
                    mem_addr_d = first_addr;
                    mem_data_d = fill_data(fill_mode_e'(mode), first_addr, fill_val);
                    mem_wren_d = 1'b1;
                    cnt_clr    = 1'b1;
                end
            end
            StFill: begin
                // Abort takes priority even on the final write.
                if (abort) begin
                    state_d = StFin;
                    abort_d = 1'b1;
                end else if (offset == span) begin
                    state_d = StFin;
                    fin_d   = 1'b1;
                end else begin
                    cnt_en     = 1'b1;
                    mem_addr_d = next_addr;
                    mem_data_d = fill_data(mode_q, next_addr, val_q);
                    mem_wren_d = 1'b1;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            mode_q     <= ModeIdent;
            first_q    <= '0;
            last_q     <= '0;
            val_q      <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_wren_q <= 1'b0;
            fin_q      <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            first_q    <= first_d;
            last_q     <= last_d;
            val_q      <= val_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_wren_q <= mem_wren_d;
            fin_q      <= fin_d;
            abort_q    <= abort_d;
        end
    end

    assign mem_addr     = mem_addr_q;
    assign mem_data     = mem_data_q;
    assign mem_wren     = mem_wren_q;
    assign busy         = (state_q == StFill);
    assign fin_strobe   = fin_q;
    assign abort_strobe = abort_q;

endmodule
